// File: rtl/bnn_layer_engine_pkg.sv
// Shared types for the binary fully-connected layer engine: FSM encoding and
// the popcount width helper used by the top and the XNOR/popcount datapath.
package bnn_layer_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam int unsigned DEF_LANES      = 32'd8;
  localparam int unsigned DEF_W_ADDR_LEN = 32'd20;
  localparam int unsigned DEF_X_ADDR_LEN = 32'd10;
  localparam int unsigned DEF_CNT_LEN    = 32'd12;

  function automatic int unsigned pop_width(input int unsigned lanes);
    return $clog2(lanes + 32'd1);
  endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR match count of one activation word against one weight
// word, restricted to the lanes enabled by mask.
module bnn_xnor_popcount
  import bnn_layer_engine_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int CW    = pop_width(LANES)
) (
  input  logic [LANES-1:0] x,
  input  logic [LANES-1:0] w,
  input  logic [LANES-1:0] mask,
  output logic [CW-1:0]    count
);

  logic [LANES-1:0] match_s;
  logic [CW-1:0]    sum_s;

  assign match_s = ~(x ^ w) & mask;

  // Sum of matching lanes.
  always_comb begin
    sum_s = CW'(0);
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + CW'(match_s[i]);
    end
  end

  assign count = sum_s;

endmodule

// File: rtl/bnn_layer_engine.sv
// One binary fully-connected layer: streams weight/activation words, accumulates
// XNOR popcounts per neuron, thresholds the score and packs result bits to X mem.
module bnn_layer_engine
  import bnn_layer_engine_pkg::*;
#(
  parameter int LANES      = DEF_LANES,
  parameter int W_ADDR_LEN = DEF_W_ADDR_LEN,
  parameter int X_ADDR_LEN = DEF_X_ADDR_LEN,
  parameter int CNT_LEN    = DEF_CNT_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_LEN-1:0]      n_in,
  input  logic [CNT_LEN-1:0]      n_out,
  input  logic [W_ADDR_LEN-1:0]   w_base,
  input  logic [X_ADDR_LEN-1:0]   x_base,
  input  logic [X_ADDR_LEN-1:0]   y_base,
  input  logic signed [CNT_LEN+1:0] thresh,
  output logic                    busy,
  output logic                    done,
  output logic [W_ADDR_LEN-1:0]   w_addr,
  output logic                    w_rq,
  input  logic [LANES-1:0]        w_rdata,
  output logic [X_ADDR_LEN-1:0]   x_addr,
  output logic                    x_rq,
  input  logic [LANES-1:0]        x_rdata,
  output logic                    x_wq,
  output logic [LANES-1:0]        x_wdata
);

  localparam int CW = pop_width(LANES);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  state_t                   state_r;
  logic [CNT_LEN-1:0]       n_in_r, n_out_r, nw_r, k_r, o_r, acc_r;
  logic [X_ADDR_LEN-1:0]    x_base_r, y_ptr_r;
  logic signed [CNT_LEN+1:0] thresh_r;
  logic [LANES-1:0]         mask_last_r, buf_r;
  logic [LW-1:0]            lane_r;
  logic                     rd_vld_r, rd_first_r, rd_last_r;

  logic [CNT_LEN-1:0]       nw_s, rem_s;
  logic [LANES-1:0]         mask_last_s, mask_s, buf_next_s;
  logic [CW-1:0]            cnt_s;
  logic signed [CNT_LEN+1:0] score_s;
  logic                     fire_s, k_last_s, o_last_s, word_end_s, dims_zero_s;

  // Word count and last-word lane mask derived from the live n_in at start.
  always_comb begin
    nw_s  = CNT_LEN'(({1'b0, n_in} + (CNT_LEN+1)'(LANES - 1)) / (CNT_LEN+1)'(LANES));
    rem_s = n_in % CNT_LEN'(LANES);
    for (int i = 0; i < LANES; i++) begin
      mask_last_s[i] = (rem_s == CNT_LEN'(0)) || (CNT_LEN'(i) < rem_s);
    end
  end

  // Per-cycle datapath decisions: mask, score, threshold and packer update.
  always_comb begin
    if (rd_last_r) begin
      mask_s = mask_last_r;
    end else begin
      mask_s = {LANES{1'b1}};
    end
    score_s            = $signed({1'b0, acc_r, 1'b0}) - $signed({2'b00, n_in_r});
    fire_s             = (score_s >= thresh_r);
    buf_next_s         = buf_r;
    buf_next_s[lane_r] = fire_s;
    k_last_s           = (k_r == nw_r - CNT_LEN'(1));
    o_last_s           = (o_r == n_out_r - CNT_LEN'(1));
    word_end_s         = (lane_r == LANE_LAST) || o_last_s;
    dims_zero_s        = (n_in == CNT_LEN'(0)) || (n_out == CNT_LEN'(0));
  end

  bnn_xnor_popcount #(.LANES(LANES), .CW(CW)) u_popcount (
    .x     (x_rdata),
    .w     (w_rdata),
    .mask  (mask_s),
    .count (cnt_s)
  );

  // Read-data pipeline: read data lands one cycle after the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_r   <= 1'b0;
      rd_first_r <= 1'b0;
      rd_last_r  <= 1'b0;
      acc_r      <= CNT_LEN'(0);
    end else begin
      rd_vld_r   <= (state_r == ST_RUN);
      rd_first_r <= (state_r == ST_RUN) && (k_r == CNT_LEN'(0));
      rd_last_r  <= (state_r == ST_RUN) && k_last_s;
      if (rd_vld_r) begin
        if (rd_first_r) begin
          acc_r <= CNT_LEN'(cnt_s);
        end else begin
          acc_r <= acc_r + CNT_LEN'(cnt_s);
        end
      end
    end
  end

  // Layer sequencer with registered memory strobes, addresses and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_addr      <= W_ADDR_LEN'(0);
      w_rq        <= 1'b0;
      x_addr      <= X_ADDR_LEN'(0);
      x_rq        <= 1'b0;
      x_wq        <= 1'b0;
      x_wdata     <= LANES'(0);
      n_in_r      <= CNT_LEN'(0);
      n_out_r     <= CNT_LEN'(0);
      nw_r        <= CNT_LEN'(0);
      k_r         <= CNT_LEN'(0);
      o_r         <= CNT_LEN'(0);
      x_base_r    <= X_ADDR_LEN'(0);
      y_ptr_r     <= X_ADDR_LEN'(0);
      thresh_r    <= (CNT_LEN+2)'(0);
      mask_last_r <= LANES'(0);
      buf_r       <= LANES'(0);
      lane_r      <= LW'(0);
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            n_in_r      <= n_in;
            n_out_r     <= n_out;
            nw_r        <= nw_s;
            x_base_r    <= x_base;
            y_ptr_r     <= y_base;
            thresh_r    <= thresh;
            mask_last_r <= mask_last_s;
            k_r         <= CNT_LEN'(0);
            o_r         <= CNT_LEN'(0);
            lane_r      <= LW'(0);
            buf_r       <= LANES'(0);
            if (dims_zero_s) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
              w_rq    <= 1'b1;
              x_rq    <= 1'b1;
              w_addr  <= w_base;
              x_addr  <= x_base;
            end
          end
        end
        ST_RUN: begin
          if (k_last_s) begin
            state_r <= ST_DRAIN;
            w_rq    <= 1'b0;
            x_rq    <= 1'b0;
          end else begin
            k_r    <= k_r + CNT_LEN'(1);
            w_addr <= w_addr + W_ADDR_LEN'(1);
            x_addr <= x_addr + X_ADDR_LEN'(1);
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (word_end_s) begin
            state_r <= ST_WRITE;
            x_wq    <= 1'b1;
            x_addr  <= y_ptr_r;
            x_wdata <= buf_next_s;
            buf_r   <= LANES'(0);
          end else begin
            buf_r   <= buf_next_s;
            state_r <= ST_RUN;
            o_r     <= o_r + CNT_LEN'(1);
            lane_r  <= lane_r + LW'(1);
            k_r     <= CNT_LEN'(0);
            w_rq    <= 1'b1;
            x_rq    <= 1'b1;
            w_addr  <= w_addr + W_ADDR_LEN'(1);
            x_addr  <= x_base_r;
          end
        end
        ST_WRITE: begin
          x_wq    <= 1'b0;
          y_ptr_r <= y_ptr_r + X_ADDR_LEN'(1);
          if (o_last_s) begin
            state_r <= ST_FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            o_r     <= o_r + CNT_LEN'(1);
            lane_r  <= LW'(0);
            k_r     <= CNT_LEN'(0);
            w_rq    <= 1'b1;
            x_rq    <= 1'b1;
            w_addr  <= w_addr + W_ADDR_LEN'(1);
            x_addr  <= x_base_r;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          w_rq    <= 1'b0;
          x_rq    <= 1'b0;
          x_wq    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed bench for bnn_layer_engine (LANES=8): vector table of layer jobs with
// hand-computed outputs and latencies, plus reset-abort and start-filter sequences.
module tb_bnn_layer_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [11:0]        n_in, n_out;
  logic [19:0]        w_base;
  logic [9:0]         x_base, y_base;
  logic signed [13:0] thresh;
  logic               busy, done, w_rq, x_rq, x_wq;
  logic [19:0]        w_addr;
  logic [9:0]         x_addr;
  logic [7:0]         w_rdata, x_rdata, x_wdata;

  bnn_layer_engine dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .n_out(n_out),
    .w_base(w_base), .x_base(x_base), .y_base(y_base), .thresh(thresh),
    .busy(busy), .done(done), .w_addr(w_addr), .w_rq(w_rq), .w_rdata(w_rdata),
    .x_addr(x_addr), .x_rq(x_rq), .x_rdata(x_rdata), .x_wq(x_wq), .x_wdata(x_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]        n_in;
    logic [11:0]        n_out;
    logic [19:0]        w_base;
    logic [9:0]         x_base;
    logic [9:0]         y_base;
    logic signed [13:0] thresh;
    logic [1:0][7:0]    x_pat;    // activation word k = x_pat[k%2]
    logic [3:0][7:0]    w_pat;    // weight word j = w_pat[j%4], j = o*NW+k
    int                 exp_nwr;
    logic [1:0][7:0]    exp_wd;
    int                 exp_cyc;
    int                 exp_rq;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  logic [7:0] wmem [256];
  logic [7:0] xmem [1024];
  logic [9:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  int wr_cnt = 0, done_cnt = 0, rq_cnt = 0, clash_cnt = 0;
  int checks = 0, errors = 0;

  // Memory models with one-cycle read latency, plus bus activity monitors.
  always @(posedge clk) begin
    if (w_rq) w_rdata <= wmem[w_addr[7:0]];
    if (x_rq) x_rdata <= xmem[x_addr];
    if (x_wq) begin
      wr_addr_log[wr_cnt % 64] <= x_addr;
      wr_data_log[wr_cnt % 64] <= x_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (w_rq || x_rq) rq_cnt <= rq_cnt + 1;
    if (x_wq && x_rq) clash_cnt <= clash_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    n_in = v.n_in; n_out = v.n_out; w_base = v.w_base;
    x_base = v.x_base; y_base = v.y_base; thresh = v.thresh;
  endtask

  task automatic fill_mem(input vec_t v);
    int nw;
    logic [19:0] wa;
    nw = (int'(v.n_in) + 7) / 8;
    for (int j = 0; j < int'(v.n_out) * nw; j++) begin
      wa = v.w_base + 20'(j);
      wmem[wa[7:0]] = v.w_pat[j % 4];
    end
    for (int k = 0; k < nw; k++) xmem[v.x_base + 10'(k)] = v.x_pat[k % 2];
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    drive(v);
    start = 1'b1;
  endtask

  // Counts edges from the start-sampling edge to the edge that raises done.
  task automatic wait_done(input int glitch_at, output int cyc, output logic busy1);
    cyc = 0;
    busy1 = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin start = 1'b0; busy1 = busy; end
      if (glitch_at != 0 && cyc == glitch_at) begin
        start = 1'b1; n_out = 12'd1; n_in = 12'd24; y_base = 10'h3F0;
      end
      if (glitch_at != 0 && cyc == glitch_at + 1) start = 1'b0;
      if (done) break;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int wr0, rq0, d0, c0, cyc;
    logic b1;
    v = vecs[i];
    fill_mem(v);
    wr0 = wr_cnt; rq0 = rq_cnt; d0 = done_cnt; c0 = clash_cnt;
    launch(v);
    wait_done(0, cyc, b1);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("v%0d_cycles", i), cyc, v.exp_cyc);
    check($sformatf("v%0d_busy", i), {31'd0, b1}, {31'd0, (v.exp_rq != 0)});
    check($sformatf("v%0d_dones", i), done_cnt - d0, 32'd1);
    check($sformatf("v%0d_reads", i), rq_cnt - rq0, v.exp_rq);
    check($sformatf("v%0d_clash", i), clash_cnt - c0, 32'd0);
    check($sformatf("v%0d_nwr", i), wr_cnt - wr0, v.exp_nwr);
    for (int w = 0; w < v.exp_nwr; w++) begin
      check($sformatf("v%0d_waddr%0d", i, w), {22'd0, wr_addr_log[(wr0 + w) % 64]}, {22'd0, v.y_base + 10'(w)});
      check($sformatf("v%0d_wdata%0d", i, w), {24'd0, wr_data_log[(wr0 + w) % 64]}, {24'd0, v.exp_wd[w]});
    end
  endtask

  initial begin
    vec_t va, vb;
    int wr0, d0, rq0, cyc;
    logic b1;

    vecs[0] = '{12'd8,  12'd1,  20'h00100, 10'h020, 10'h040, 14'sd0,   16'hFFFF, 32'hFFFFFFFF, 1, 16'h0001, 5,  1};
    vecs[1] = '{12'd12, 12'd1,  20'h00200, 10'h022, 10'h041, -14'sd12, 16'hFFFF, 32'hF000F000, 1, 16'h0001, 6,  2};
    vecs[2] = '{12'd12, 12'd1,  20'h00200, 10'h022, 10'h042, -14'sd11, 16'hFFFF, 32'hF000F000, 1, 16'h0000, 6,  2};
    vecs[3] = '{12'd8,  12'd10, 20'h00300, 10'h024, 10'h044, 14'sd0,   16'hFFFF, 32'hFFFFFFFF, 2, 16'h03FF, 33, 10};
    vecs[4] = '{12'd16, 12'd3,  20'h00400, 10'h026, 10'h048, 14'sd0,   16'h3CA5, 32'hC3A5C3A5, 1, 16'h0007, 14, 6};
    vecs[5] = '{12'd3,  12'd2,  20'h00500, 10'h028, 10'h04A, -14'sd1,  16'h0005, 32'h06060606, 1, 16'h0003, 8,  2};
    vecs[6] = '{12'd8,  12'd4,  20'hFFFFF, 10'h02A, 10'h04C, 14'sd0,   16'hFFFF, 32'h00FF00FF, 1, 16'h0005, 14, 4};
    vecs[7] = '{12'd8,  12'd0,  20'h00000, 10'h020, 10'h060, 14'sd0,   16'hFFFF, 32'hFFFFFFFF, 0, 16'h0000, 1,  0};
    vecs[8] = '{12'd0,  12'd3,  20'h00000, 10'h020, 10'h060, 14'sd0,   16'hFFFF, 32'hFFFFFFFF, 0, 16'h0000, 1,  0};
    vecs[9] = '{12'd20, 12'd9,  20'h00600, 10'h02C, 10'h04E, 14'sd4,   16'hFFFF, 32'h0F0F0F0F, 2, 16'h01FF, 48, 27};

    rst = 1'b0; start = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {27'd0, busy, done, w_rq, x_rq, x_wq}, 32'd0);
    check("reset_addr", {2'd0, w_addr, x_addr}, 32'd0);
    check("reset_wdata", {24'd0, x_wdata}, 32'd0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Asynchronous reset in the middle of a long layer.
    va = vecs[3]; va.n_in = 12'd64; va.n_out = 12'd16; va.y_base = 10'h070;
    wr0 = wr_cnt; d0 = done_cnt;
    launch(va);
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort_pre_run", {30'd0, busy, w_rq}, 32'd3);
    rst = 1'b0;
    #1;
    check("abort_ctrl", {27'd0, busy, done, w_rq, x_rq, x_wq}, 32'd0);
    check("abort_addr", {2'd0, w_addr, x_addr}, 32'd0);
    @(negedge clk) rst = 1'b1;
    rq0 = rq_cnt;
    repeat (200) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_no_write", wr_cnt - wr0, 32'd0);
    check("abort_idle_bus", rq_cnt - rq0, 32'd0);

    // Start while busy is ignored; start in FIN ignored; start next cycle accepted.
    va = vecs[3]; va.y_base = 10'h050;
    vb = vecs[0]; vb.y_base = 10'h058;
    fill_mem(va);
    wr0 = wr_cnt; d0 = done_cnt;
    launch(va);
    wait_done(5, cyc, b1);
    check("busy_start_cycles", cyc, 32'd33);
    fill_mem(vb);
    drive(vb);
    start = 1'b1;
    @(posedge clk); #1;
    check("fin_start_ignored", {30'd0, busy, w_rq}, 32'd0);
    wait_done(0, cyc, b1);
    check("after_done_cycles", cyc, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    check("seq_dones", done_cnt - d0, 32'd2);
    check("seq_nwr", wr_cnt - wr0, 32'd3);
    check("seq_waddr0", {22'd0, wr_addr_log[wr0 % 64]}, 32'h050);
    check("seq_wdata0", {24'd0, wr_data_log[wr0 % 64]}, 32'hFF);
    check("seq_waddr1", {22'd0, wr_addr_log[(wr0 + 1) % 64]}, 32'h051);
    check("seq_wdata1", {24'd0, wr_data_log[(wr0 + 1) % 64]}, 32'h03);
    check("seq_waddr2", {22'd0, wr_addr_log[(wr0 + 2) % 64]}, 32'h058);
    check("seq_wdata2", {24'd0, wr_data_log[(wr0 + 2) % 64]}, 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
